// File: rtl/binary_maxpool.sv
// 2x2 binary max-pool stage: reads a header plus N tile words from SRAM, ORs each
// tile's four bits into one pooled bit, and packs 16 pooled bits per output word.
module binary_maxpool (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        dut_run,
    output logic        dut_busy,
    output logic [11:0] dut_sram_read_address,
    input  logic [15:0] sram_dut_read_data,
    output logic [11:0] dut_sram_write_address,
    output logic [15:0] dut_sram_write_data,
    output logic        dut_sram_write_enable
);

    localparam logic [11:0] IN_BASE   = 12'h000;
    localparam logic [11:0] OUT_BASE  = 12'h800;
    localparam logic [10:0] MAX_TILES = 11'd1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    function automatic logic pool_tile(input logic [15:0] tile);
        return |tile[3:0];
    endfunction

    function automatic logic [10:0] clamp_count(input logic [10:0] raw);
        if (raw > MAX_TILES) begin
            return MAX_TILES;
        end else begin
            return raw;
        end
    endfunction

    state_t      state_r;
    logic        hdr_phase_r;
    logic [10:0] n_tiles_r;
    logic [10:0] tile_cnt_r;
    logic [15:0] acc_r;
    logic [3:0]  idx_r;
    logic [11:0] word_cnt_r;

    logic [15:0] acc_next_s;
    logic        last_tile_s;
    logic        group_full_s;
    logic [10:0] hdr_count_s;

    // Next accumulator value and word-boundary conditions for the tile on the bus
    always_comb begin
        acc_next_s   = acc_r | ({15'd0, pool_tile(sram_dut_read_data)} << idx_r);
        hdr_count_s  = clamp_count(sram_dut_read_data[10:0]);
        group_full_s = 1'b0;
        last_tile_s  = 1'b0;
        if (state_r == ST_STREAM) begin
            group_full_s = (idx_r == 4'd15);
            last_tile_s  = (tile_cnt_r == (n_tiles_r - 11'd1));
        end else begin
            group_full_s = 1'b0;
            last_tile_s  = 1'b0;
        end
    end

    // Control FSM, packing datapath and registered SRAM interface
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_r                <= ST_IDLE;
            hdr_phase_r            <= 1'b0;
            n_tiles_r              <= 11'd0;
            tile_cnt_r             <= 11'd0;
            acc_r                  <= 16'd0;
            idx_r                  <= 4'd0;
            word_cnt_r             <= 12'd0;
            dut_busy               <= 1'b0;
            dut_sram_read_address  <= 12'd0;
            dut_sram_write_address <= 12'd0;
            dut_sram_write_data    <= 16'd0;
            dut_sram_write_enable  <= 1'b0;
        end else begin
            dut_sram_write_enable <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (dut_run) begin
                        state_r               <= ST_FETCH;
                        dut_busy              <= 1'b1;
                        dut_sram_read_address <= IN_BASE;
                        hdr_phase_r           <= 1'b0;
                        tile_cnt_r            <= 11'd0;
                        acc_r                 <= 16'd0;
                        idx_r                 <= 4'd0;
                        word_cnt_r            <= 12'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    dut_sram_read_address <= dut_sram_read_address + 12'd1;
                    // First FETCH cycle only presents the header address; data lands in the second
                    if (!hdr_phase_r) begin
                        hdr_phase_r <= 1'b1;
                    end else begin
                        n_tiles_r <= hdr_count_s;
                        if (hdr_count_s == 11'd0) begin
                            state_r  <= ST_IDLE;
                            dut_busy <= 1'b0;
                        end else begin
                            state_r <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    dut_sram_read_address <= dut_sram_read_address + 12'd1;
                    tile_cnt_r            <= tile_cnt_r + 11'd1;
                    if (group_full_s || last_tile_s) begin
                        dut_sram_write_address <= OUT_BASE + word_cnt_r;
                        dut_sram_write_data    <= acc_next_s;
                        dut_sram_write_enable  <= 1'b1;
                        word_cnt_r             <= word_cnt_r + 12'd1;
                        acc_r                  <= 16'd0;
                        idx_r                  <= 4'd0;
                    end else begin
                        acc_r <= acc_next_s;
                        idx_r <= idx_r + 4'd1;
                    end
                    if (last_tile_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_DRAIN: begin
                    state_r  <= ST_IDLE;
                    dut_busy <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    dut_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
